reg_file_demux: RTL and testbench
=================================

Name: reg_file_demux

Overview:
- Write-side counterpart to the datapath's bus-select muxes.
- Takes the single 16-bit shared datapath bus and demultiplexes it into one of 8 general-purpose registers, selected by a 3-bit destination select.
- Provides two combinational read ports (SR1, SR2) into the ALU/address logic.
- Maintains the NZP condition-code register from bus data.
- Sits between the bus gate mux and the ALU/ADDR operand muxes; controlled by the ISDU.

Parameters:
- DATA_W, 16, width of the bus and of each register
- NUM_REGS, 8, number of general-purpose registers
- ADDR_W, 3, width of the DR/SR1/SR2 selects; NUM_REGS must equal 2**ADDR_W

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- bus_in  input  DATA_W  shared datapath bus value
- dr_select  input  ADDR_W  destination register index
- ld_reg  input  1  write enable for the register addressed by dr_select
- sr1_select  input  ADDR_W  read port 1 index
- sr2_select  input  ADDR_W  read port 2 index
- ld_cc  input  1  load enable for the condition codes
- sr1_out  output  DATA_W  contents of register sr1_select
- sr2_out  output  DATA_W  contents of register sr2_select
- nzp_out  output  3  condition codes {N,Z,P}
- reg_written  output  1  registered pulse: high for one cycle after each completed write

Behaviour:
- Clock and reset are fixed: one clock, Clk; reset is asynchronous and active-low, Reset_n.
- Reset (Reset_n=0, asynchronous):
  - all registers become 16'h0000
  - nzp_out becomes 3'b010
  - reg_written becomes 0
  - all hold while Reset_n=0
- Reset deasserted mid-operation: no write occurs on the edge where Reset_n is low; the first write happens on the first rising edge with Reset_n=1.
- Write path:
  - decode dr_select to a one-hot load vector, gated by ld_reg; exactly one register loads bus_in on the rising edge.
  - ld_reg=0 means no register changes.
  - all other registers hold.
- Read path:
  - sr1_out and sr2_out are purely combinational from the register array (0-cycle latency).
  - sr1_select == sr2_select is legal; both outputs show the same value.
- Write/read same register in the same cycle (without the optional feature): read returns the old value; the new value is visible the cycle after the edge.
- Condition codes, on a rising edge with ld_cc=1, from signed bus_in:
  - bus_in[15]=1 gives N: 3'b100
  - bus_in==0 gives Z: 3'b010
  - otherwise P: 3'b001
  - ld_cc=0 holds the previous value.
  - ld_cc is independent of ld_reg; both may assert in one cycle.
- reg_written: set to 1 on the edge where ld_reg=1, cleared on the next edge unless ld_reg is still 1. Back-to-back writes hold it high.
- No arithmetic wrap: data is stored verbatim, no width conversion.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: when ld_reg=1 and dr_select equals srN_select, srN_out combinationally returns bus_in (write-through forwarding). This applies to each port independently.
- Undefined: no forwarding; reads always return stored contents, and the same-cycle read returns the old value.

Decomposition:
- Shared package slc3_pkg:
  - constants DATA_W=16 and REG_ADDR_W=3
  - typedef word_t (logic [15:0])
  - typedef reg_idx_t (logic [2:0])
  - typedef nzp_t (logic [2:0])
  - localparams NZP_N=3'b100, NZP_Z=3'b010, NZP_P=3'b001
- Sub-module: load_reg_16, a 16-bit register with load enable and async active-low reset, instantiated NUM_REGS times.
- Decoder, read muxes and NZP logic stay in the top.

Test Plan:
- Reset: assert Reset_n=0 mid-cycle with registers nonzero -> immediately all reads return 16'h0000, nzp_out=3'b010, reg_written=0.
- Write/readback: for each DR 0..7 write bus_in=16'h1110+DR with ld_reg=1 -> next cycle sr1_out and sr2_out at index k read 16'h1110+k; reg_written pulses exactly once per write.
- Hold: ld_reg=0, dr_select=3, bus_in=16'hDEAD -> R3 unchanged (16'h1113).
- Condition codes with ld_cc=1:
  - bus_in=16'h8000 -> nzp=3'b100
  - bus_in=16'h0000 -> nzp=3'b010
  - bus_in=16'h7FFF -> nzp=3'b001
  - ld_cc=0 with bus_in=16'h8000 -> nzp stays 3'b001
- Same-cycle hazard: ld_reg=1, dr_select=sr1_select=5, bus_in=16'hBEEF -> with bypass off, sr1_out shows the old value 16'h1115 that cycle; with bypass on, sr1_out shows 16'hBEEF that cycle. Both show 16'hBEEF next cycle.
- Simultaneous: ld_reg=1 and ld_cc=1 with bus_in=16'hFFFF, dr_select=0 -> R0=16'hFFFF and nzp=3'b100 after the same edge.

Source files
------------

// File: rtl/slc3_pkg.sv
// Shared datapath types and constants for the SLC-3 register file slice.
// Word, register index and condition-code encodings used across stages.
package slc3_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    typedef logic [DATA_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [2:0]            nzp_t;

    localparam nzp_t NZP_N = 3'b100;
    localparam nzp_t NZP_Z = 3'b010;
    localparam nzp_t NZP_P = 3'b001;

endpackage

// File: rtl/load_reg_16.sv
// 16-bit register with load enable and asynchronous active-low reset.
// One instance per general-purpose register in reg_file_demux.
module load_reg_16
    import slc3_pkg::*;
(
    input  logic  Clk,
    input  logic  Reset_n,
    input  logic  ld,
    input  word_t din,
    output word_t dout
);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dout <= '0;
        end else if (ld) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/reg_file_demux.sv
// Bus-to-register demux, two combinational read ports and NZP codes.
// Optional write-through forwarding: define REGFILE_BYPASS_EN.
module reg_file_demux #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic [ADDR_W-1:0] dr_select,
    input  logic              ld_reg,
    input  logic [ADDR_W-1:0] sr1_select,
    input  logic [ADDR_W-1:0] sr2_select,
    input  logic              ld_cc,
    output logic [DATA_W-1:0] sr1_out,
    output logic [DATA_W-1:0] sr2_out,
    output logic [2:0]        nzp_out,
    output logic              reg_written
);

    import slc3_pkg::*;

    if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_regs
        $error("NUM_REGS must equal 2**ADDR_W");
    end
    if (DATA_W != 16) begin : g_bad_width
        $error("load_reg_16 storage requires DATA_W == 16");
    end

    logic [NUM_REGS-1:0] ld_vec;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    nzp_t                nzp_q;
    nzp_t                nzp_next;
    logic                written_q;

    always_comb begin
        ld_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            ld_vec[i] = ld_reg && (dr_select == ADDR_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        load_reg_16 u_reg (
            .Clk     (Clk),
            .Reset_n (Reset_n),
            .ld      (ld_vec[g]),
            .din     (bus_in),
            .dout    (regs[g])
        );
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the bus when the port reads the register being written.
    always_comb begin
        sr1_out = regs[sr1_select];
        sr2_out = regs[sr2_select];
        if (ld_reg && (dr_select == sr1_select)) begin
            sr1_out = bus_in;
        end
        if (ld_reg && (dr_select == sr2_select)) begin
            sr2_out = bus_in;
        end
    end
`else
    always_comb begin
        sr1_out = regs[sr1_select];
        sr2_out = regs[sr2_select];
    end
`endif

    always_comb begin
        nzp_next = NZP_P;
        unique case (1'b1)
            bus_in[DATA_W-1]: nzp_next = NZP_N;
            (bus_in == '0):   nzp_next = NZP_Z;
            default:          nzp_next = NZP_P;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            nzp_q <= NZP_Z;
        end else if (ld_cc) begin
            nzp_q <= nzp_next;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            written_q <= 1'b0;
        end else begin
            written_q <= ld_reg;
        end
    end

    assign nzp_out     = nzp_q;
    assign reg_written = written_q;

endmodule

// File: tb/tb_reg_file_demux.sv
// Scoreboard bench for reg_file_demux.
// Expected values are queued at stimulus time and popped when observed.
module tb_reg_file_demux;

    logic        Clk;
    logic        Reset_n;
    logic [15:0] bus_in;
    logic [2:0]  dr_select;
    logic        ld_reg;
    logic [2:0]  sr1_select;
    logic [2:0]  sr2_select;
    logic        ld_cc;
    logic [15:0] sr1_out;
    logic [15:0] sr2_out;
    logic [2:0]  nzp_out;
    logic        reg_written;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    reg_file_demux dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .bus_in      (bus_in),
        .dr_select   (dr_select),
        .ld_reg      (ld_reg),
        .sr1_select  (sr1_select),
        .sr2_select  (sr2_select),
        .ld_cc       (ld_cc),
        .sr1_out     (sr1_out),
        .sr2_out     (sr2_out),
        .nzp_out     (nzp_out),
        .reg_written (reg_written)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop(input logic [15:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_empty got=%h exp=none", got);
        end else begin
            e = sb.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        Reset_n    = 1'b1;
        bus_in     = '0;
        dr_select  = '0;
        ld_reg     = 1'b0;
        sr1_select = '0;
        sr2_select = 3'd7;
        ld_cc      = 1'b0;
        #2 Reset_n = 1'b0;
        tick();
        tick();
        push("rst_sr1", 16'h0000);
        push("rst_sr2", 16'h0000);
        push("rst_nzp", 16'h0002);
        push("rst_rw", 16'h0000);
        pop(sr1_out);
        pop(sr2_out);
        pop({13'd0, nzp_out});
        pop({15'd0, reg_written});
        Reset_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            dr_select = 3'(k);
            bus_in    = 16'h1110 + 16'(k);
            ld_reg    = 1'b1;
            tick();
            ld_reg = 1'b0;
            push($sformatf("wr_rw_hi%0d", k), 16'h0001);
            pop({15'd0, reg_written});
            tick();
            push($sformatf("wr_rw_lo%0d", k), 16'h0000);
            pop({15'd0, reg_written});
        end

        for (int k = 0; k < 8; k++) begin
            sr1_select = 3'(k);
            sr2_select = 3'(7 - k);
            push($sformatf("rd_sr1_%0d", k), 16'h1110 + 16'(k));
            push($sformatf("rd_sr2_%0d", k), 16'h1117 - 16'(k));
            #1;
            pop(sr1_out);
            pop(sr2_out);
        end

        dr_select = 3'd6;
        bus_in    = 16'h1116;
        ld_reg    = 1'b1;
        tick();
        push("b2b_rw1", 16'h0001);
        pop({15'd0, reg_written});
        tick();
        push("b2b_rw2", 16'h0001);
        pop({15'd0, reg_written});
        ld_reg = 1'b0;

        dr_select  = 3'd3;
        bus_in     = 16'hDEAD;
        sr1_select = 3'd3;
        tick();
        push("hold_r3", 16'h1113);
        pop(sr1_out);

        ld_cc  = 1'b1;
        bus_in = 16'h8000;
        tick();
        push("cc_n", 16'h0004);
        pop({13'd0, nzp_out});
        bus_in = 16'h0000;
        tick();
        push("cc_z", 16'h0002);
        pop({13'd0, nzp_out});
        bus_in = 16'h7FFF;
        tick();
        push("cc_p", 16'h0001);
        pop({13'd0, nzp_out});
        ld_cc  = 1'b0;
        bus_in = 16'h8000;
        tick();
        push("cc_hold", 16'h0001);
        pop({13'd0, nzp_out});

        ld_reg     = 1'b1;
        dr_select  = 3'd5;
        sr1_select = 3'd5;
        sr2_select = 3'd4;
        bus_in     = 16'hBEEF;
`ifdef REGFILE_BYPASS_EN
        push("haz_same", 16'hBEEF);
`else
        push("haz_same", 16'h1115);
`endif
        push("haz_other", 16'h1114);
        #1;
        pop(sr1_out);
        pop(sr2_out);
        tick();
        ld_reg = 1'b0;
        push("haz_next", 16'hBEEF);
        pop(sr1_out);

        ld_reg     = 1'b1;
        ld_cc      = 1'b1;
        dr_select  = 3'd0;
        bus_in     = 16'hFFFF;
        sr1_select = 3'd0;
        tick();
        ld_reg = 1'b0;
        ld_cc  = 1'b0;
        push("sim_r0", 16'hFFFF);
        push("sim_nzp", 16'h0004);
        pop(sr1_out);
        pop({13'd0, nzp_out});

        ld_reg    = 1'b1;
        dr_select = 3'd7;
        bus_in    = 16'h0123;
        tick();
        sr2_select = 3'd5;
        #2 Reset_n = 1'b0;
        #1;
        push("arst_sr1", 16'h0000);
        push("arst_sr2", 16'h0000);
        push("arst_nzp", 16'h0002);
        push("arst_rw", 16'h0000);
        pop(sr1_out);
        pop(sr2_out);
        pop({13'd0, nzp_out});
        pop({15'd0, reg_written});

        dr_select  = 3'd2;
        bus_in     = 16'hAAAA;
        sr1_select = 3'd2;
        tick();
        push("rstlo_nowr", 16'h0000);
        pop(sr1_out);
        #2 Reset_n = 1'b1;
        tick();
        ld_reg = 1'b0;
        push("rel_wr", 16'hAAAA);
        pop(sr1_out);

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
